// File: rtl/etapa_memoria.sv
// etapa_memoria
//  Memory / pass-through stage that sits right after the ALU.
//  Loads (LW, LB) and stores (SW) use the ALU result as a byte address and run a
//  req/ack handshake on the data-memory port. While that access is outstanding
//  the stage holds the upstream pipeline through a combinational stall.
//  Every other opcode is registered straight through to writeback in one cycle.
//
//  Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   valid_in, opcode,
//   resultado, dato_sw,
//   rd_in                    op presented by the ALU stage
//   stall                    1 while a memory access is outstanding
//   mem_req, mem_we,
//   mem_addr, mem_wdata      request side of the data-memory port (held while waiting)
//   mem_rdata, mem_ack       response side; rdata valid with the one-cycle ack
//   valid_out, wb_dato,
//   wb_rd, wb_we             writeback fields; wb_* hold their value between pulses
//   mem_error                sticky: misaligned LW or memory timeout, cleared by rst
module etapa_memoria #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [4:0]  opcode,
   input  logic [31:0] resultado,
   input  logic [31:0] dato_sw,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        valid_out,
   output logic [31:0] wb_dato,
   output logic [4:0]  wb_rd,
   output logic        wb_we,
   output logic        mem_error
);

   localparam logic [4:0]  OP_LW   = 5'd12;
   localparam logic [4:0]  OP_LB   = 5'd13;
   localparam logic [4:0]  OP_SW   = 5'd14;
   localparam logic [4:0]  OP_ADDI = 5'd15;
   localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
   // Counter value seen on the last cycle a request may stay open without ack.
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [4:0]  op_p1;
   logic [4:0]  rd_p1;
   logic [1:0]  sel_p1;

   function automatic logic is_mem(input logic [4:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_SW);
   endfunction

   // Register-file write only for arithmetic ops (1..9) and ADDI; branches,
   // jumps, NOP and unknown encodings never write.
   function automatic logic wb_enable(input logic [4:0] op);
      return ((op >= 5'd1) && (op <= 5'd9)) || (op == OP_ADDI);
   endfunction

   // Little-endian byte pick followed by sign extension.
   function automatic logic [31:0] lb_extend(input logic [31:0] word, input logic [1:0] sel);
      logic signed [7:0] b;
      case (sel)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         2'd3: b = word[31:24];
      endcase
      return {{24{b[7]}}, b};
   endfunction

   assign stall = (state == ST_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 32'd0;
         op_p1     <= 5'd0;
         rd_p1     <= 5'd0;
         sel_p1    <= 2'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         valid_out <= 1'b0;
         wb_dato   <= 32'd0;
         wb_rd     <= 5'd0;
         wb_we     <= 1'b0;
         mem_error <= 1'b0;
      end else begin
         case (state)
            // ---- accept stage: decode the incoming op ----
            ST_IDLE: begin
               valid_out <= 1'b0;
               if (valid_in) begin
                  if (opcode == OP_LW && resultado[1:0] != 2'b00) begin
                     // Misaligned word load never reaches memory.
                     mem_error <= 1'b1;
                     valid_out <= 1'b1;
                     wb_we     <= 1'b0;
                     wb_dato   <= 32'd0;
                     wb_rd     <= rd_in;
                  end else if (is_mem(opcode)) begin
                     state     <= ST_WAIT;
                     cnt       <= 32'd0;
                     op_p1     <= opcode;
                     rd_p1     <= rd_in;
                     sel_p1    <= resultado[1:0];
                     mem_req   <= 1'b1;
                     mem_we    <= (opcode == OP_SW);
                     mem_addr  <= {resultado[31:2], 2'b00};
                     mem_wdata <= dato_sw;
                  end else begin
                     valid_out <= 1'b1;
                     wb_dato   <= resultado;
                     wb_rd     <= rd_in;
                     wb_we     <= wb_enable(opcode);
                  end
               end
            end
            // ---- memory stage: hold the request until ack or timeout ----
            ST_WAIT: begin
               if (mem_ack) begin
                  // An ack on the timeout cycle still completes the access.
                  state     <= ST_IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  valid_out <= 1'b1;
                  wb_rd     <= rd_p1;
                  case (op_p1)
                     OP_LW: begin
                        wb_dato <= mem_rdata;
                        wb_we   <= 1'b1;
                     end
                     OP_LB: begin
                        wb_dato <= lb_extend(mem_rdata, sel_p1);
                        wb_we   <= 1'b1;
                     end
                     default: begin
                        wb_dato <= 32'd0;
                        wb_we   <= 1'b0;
                     end
                  endcase
               end else if (TO_EN && cnt == TO_LAST) begin
                  state     <= ST_IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_error <= 1'b1;
                  valid_out <= 1'b1;
                  wb_dato   <= 32'd0;
                  wb_rd     <= rd_p1;
                  wb_we     <= 1'b0;
               end else begin
                  cnt       <= cnt + 32'd1;
                  valid_out <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_etapa_memoria.sv
module tb_etapa_memoria;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [4:0]  opcode = 5'd0;
   logic [31:0] resultado = 32'd0;
   logic [31:0] dato_sw = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;
   logic        valid_out;
   logic [31:0] wb_dato;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic        mem_error;

   int checks = 0;
   int errors = 0;

   etapa_memoria #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
      .resultado(resultado), .dato_sw(dato_sw), .rd_in(rd_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .valid_out(valid_out), .wb_dato(wb_dato), .wb_rd(wb_rd),
      .wb_we(wb_we), .mem_error(mem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // One pending transaction record plus the expected visible outputs.
   bit          m_busy = 0;
   int          m_age = 0;       // cycles the request has been open without ack
   logic [4:0]  m_op = 0;
   logic [4:0]  m_rd = 0;
   logic [31:0] m_addr = 0;
   logic        e_valid = 0, e_we = 0, e_req = 0, e_mwe = 0, e_err = 0;
   logic [31:0] e_dato = 0, e_maddr = 0, e_mwdata = 0;
   logic [4:0]  e_rd = 0;
   bit          e_dknown = 1;

   function automatic logic [31:0] sext_byte(input logic [31:0] w, input logic [1:0] s);
      int b;
      b = int'((w >> (8 * s)) & 32'hFF);
      if (b >= 128) b = b - 256;
      return 32'(b);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_age = 0; m_op = 0; m_rd = 0; m_addr = 0;
         e_valid = 0; e_we = 0; e_req = 0; e_mwe = 0; e_err = 0;
         e_dato = 0; e_maddr = 0; e_mwdata = 0; e_rd = 0; e_dknown = 1;
      end else if (!m_busy) begin
         e_valid = 0;
         if (valid_in) begin
            if (opcode == 5'd12 && resultado[1:0] != 2'b00) begin
               e_err = 1; e_valid = 1; e_we = 0; e_rd = rd_in; e_dknown = 0;
            end else if (opcode inside {5'd12, 5'd13, 5'd14}) begin
               m_busy = 1; m_age = 0; m_op = opcode; m_rd = rd_in; m_addr = resultado;
               e_req = 1; e_mwe = (opcode == 5'd14);
               e_maddr = resultado & ~32'h3; e_mwdata = dato_sw;
            end else begin
               e_valid = 1; e_dato = resultado; e_rd = rd_in; e_dknown = 1;
               e_we = ((opcode >= 5'd1) && (opcode <= 5'd9)) || (opcode == 5'd15);
            end
         end
      end else begin
         e_valid = 0;
         if (mem_ack) begin
            m_busy = 0; e_req = 0; e_valid = 1; e_rd = m_rd; e_dknown = 1;
            if (m_op == 5'd12) begin e_dato = mem_rdata; e_we = 1; end
            else if (m_op == 5'd13) begin e_dato = sext_byte(mem_rdata, m_addr[1:0]); e_we = 1; end
            else begin e_dato = 0; e_we = 0; end
         end else if (TO != 0 && m_age + 1 == TO) begin
            m_busy = 0; e_req = 0; e_err = 1; e_valid = 1; e_we = 0; e_rd = m_rd; e_dknown = 0;
         end else begin
            m_age++;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("stall", {31'd0, stall}, {31'd0, m_busy});
         chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
         chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
         chk("mem_error", {31'd0, mem_error}, {31'd0, e_err});
         chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
         chk("wb_we", {31'd0, wb_we}, {31'd0, e_we});
         if (e_dknown) chk("wb_dato", wb_dato, e_dato);
         if (e_req) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_mwe});
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_wdata", mem_wdata, e_mwdata);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic put_op(input logic [4:0] op, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd);
      valid_in = 1'b1; opcode = op; resultado = res; dato_sw = sd; rd_in = rd;
   endtask

   initial begin
      int stall_n, req_n, age, delay, r;
      bit done;

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_error", {31'd0, mem_error}, 32'd0);
      chk("rst_wb_dato", wb_dato, 32'd0);
      rst = 1'b0;

      // ADD passes through in one cycle
      put_op(5'd1, 32'h1234, 32'd0, 5'd5);
      @(negedge clk); valid_in = 1'b0;
      chk("add_valid", {31'd0, valid_out}, 32'd1);
      chk("add_dato", wb_dato, 32'h1234);
      chk("add_rd", {27'd0, wb_rd}, 32'd5);
      chk("add_we", {31'd0, wb_we}, 32'd1);
      @(negedge clk);
      chk("add_pulse", {31'd0, valid_out}, 32'd0);

      // LB at 0x103, ack on the 4th waiting cycle (also the timeout cycle)
      put_op(5'd13, 32'h103, 32'd0, 5'd7);
      @(negedge clk);
      put_op(5'd1, 32'hFFFF, 32'd0, 5'd1);   // ignored while waiting
      chk("lb_req", {31'd0, mem_req}, 32'd1);
      chk("lb_addr", mem_addr, 32'h100);
      chk("lb_mem_we", {31'd0, mem_we}, 32'd0);
      stall_n = 0;
      for (int i = 0; i < 4; i++) begin
         if (stall) stall_n++;
         mem_ack = (i == 3);
         mem_rdata = (i == 3) ? 32'h80FF_0000 : $urandom;
         if (i == 3) valid_in = 1'b0;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("lb_stall_cycles", stall_n, 4);
      chk("lb_stall_released", {31'd0, stall}, 32'd0);
      chk("lb_valid", {31'd0, valid_out}, 32'd1);
      chk("lb_dato", wb_dato, 32'hFFFF_FF80);
      chk("lb_we", {31'd0, wb_we}, 32'd1);
      chk("lb_rd", {27'd0, wb_rd}, 32'd7);

      // SW with ack in the first waiting cycle
      put_op(5'd14, 32'h40, 32'hDEAD_BEEF, 5'd3);
      @(negedge clk); valid_in = 1'b0;
      chk("sw_req", {31'd0, mem_req}, 32'd1);
      chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_addr", mem_addr, 32'h40);
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      chk("sw_valid", {31'd0, valid_out}, 32'd1);
      chk("sw_wb_we", {31'd0, wb_we}, 32'd0);
      chk("sw_dato", wb_dato, 32'd0);
      chk("sw_stall", {31'd0, stall}, 32'd0);

      // LW with no ack: timeout after TO cycles
      put_op(5'd12, 32'h200, 32'd0, 5'd9);
      @(negedge clk); valid_in = 1'b0;
      req_n = 0; done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (mem_req) begin
            req_n++;
            @(negedge clk);
         end else begin
            done = 1;
            chk("to_valid", {31'd0, valid_out}, 32'd1);
            chk("to_wb_we", {31'd0, wb_we}, 32'd0);
         end
      end
      chk("to_finished", {31'd0, done}, 32'd1);
      chk("to_req_cycles", req_n, TO);
      chk("to_error", {31'd0, mem_error}, 32'd1);
      chk("to_stall", {31'd0, stall}, 32'd0);

      // Reset in the middle of a wait
      put_op(5'd12, 32'h80, 32'd0, 5'd4);
      @(negedge clk); valid_in = 1'b0;
      chk("rw_stall_before", {31'd0, stall}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rw_req", {31'd0, mem_req}, 32'd0);
      chk("rw_stall", {31'd0, stall}, 32'd0);
      chk("rw_error_cleared", {31'd0, mem_error}, 32'd0);
      @(negedge clk); rst = 1'b0; mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      chk("rw_late_ack", {31'd0, valid_out}, 32'd0);
      put_op(5'd1, 32'h55, 32'd0, 5'd12);
      @(negedge clk); valid_in = 1'b0;
      chk("rw_add_valid", {31'd0, valid_out}, 32'd1);
      chk("rw_add_dato", wb_dato, 32'h55);
      chk("rw_add_rd", {27'd0, wb_rd}, 32'd12);

      // Misaligned LW
      put_op(5'd12, 32'h41, 32'd0, 5'd6);
      @(negedge clk); valid_in = 1'b0;
      chk("mis_req", {31'd0, mem_req}, 32'd0);
      chk("mis_error", {31'd0, mem_error}, 32'd1);
      chk("mis_valid", {31'd0, valid_out}, 32'd1);
      chk("mis_wb_we", {31'd0, wb_we}, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("mis_req_later", {31'd0, mem_req}, 32'd0);

      // Randomized traffic against the model
      age = 0; delay = 0;
      for (int c = 0; c < 3000; c++) begin
         mem_rdata = $urandom;
         if (mem_req) begin
            if (age == 0) delay = $urandom_range(0, 5);
            mem_ack = (age == delay);
            age++;
         end else begin
            age = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
         end
         valid_in = ($urandom_range(0, 4) != 0);
         r = $urandom_range(0, 9);
         opcode = (r < 4) ? 5'(12 + $urandom_range(0, 2)) : 5'($urandom_range(0, 31));
         resultado = $urandom;
         if (opcode == 5'd12 && $urandom_range(0, 1) == 1) resultado[1:0] = 2'b00;
         dato_sw = $urandom;
         rd_in = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      mem_ack = 1'b0;
      repeat (TO + 4) @(negedge clk);
      chk("end_idle", {31'd0, stall}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
